johnson_monitor: RTL and testbench

//  Downstream consumer of the 4-bit Johnson up/down counter output. Samples the

---
 rtl/johnson_monitor.sv | 129 ++++++++++++
 tb/tb_johnson_monitor.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/johnson_monitor.sv
// Johnson counter checker: decodes the 4-bit code to a step index,
// tracks direction and wrap, and counts skipped or illegal codes.
module johnson_monitor #(
  parameter int CNT_W    = 8,
  parameter int ERR_W    = 4,
  parameter int RESYNC_N = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       signal,
  output logic [2:0]       index,
  output logic             valid,
  output logic             dir_down,
  output logic             step,
  output logic             wrap,
  output logic             illegal,
  output logic [CNT_W-1:0] step_count,
  output logic [ERR_W-1:0] error_count
);

  localparam logic [1:0] S_SYNC  = 2'd0;
  localparam logic [1:0] S_LOCK  = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;
  localparam int GW = (RESYNC_N < 2) ? 1 : $clog2(RESYNC_N + 1);

  logic [1:0]    state;
  logic [2:0]    prev;
  logic [GW-1:0] good_cnt;
  logic          anchor;
  logic          legal;
  logic [2:0]    sidx;
  logic [2:0]    diff;
  logic          adj;

  always_comb begin
    legal = 1'b1;
    sidx  = 3'd0;
    unique case (signal)
      4'b0000: sidx = 3'd0;
      4'b0001: sidx = 3'd1;
      4'b0011: sidx = 3'd2;
      4'b0111: sidx = 3'd3;
      4'b1111: sidx = 3'd4;
      4'b1110: sidx = 3'd5;
      4'b1100: sidx = 3'd6;
      4'b1000: sidx = 3'd7;
      default: legal = 1'b0;
    endcase
  end

  // Mod-8 distance; 0/1/7 are the only moves a healthy counter makes
  assign diff = sidx - prev;
  assign adj  = legal &&
    (diff == 3'd0 || diff == 3'd1 || diff == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_SYNC;
      prev        <= '0;
      good_cnt    <= '0;
      anchor      <= 1'b0;
      index       <= '0;
      valid       <= 1'b0;
      dir_down    <= 1'b0;
      step        <= 1'b0;
      wrap        <= 1'b0;
      illegal     <= 1'b0;
      step_count  <= '0;
      error_count <= '0;
    end else begin
      illegal <= !legal;
      step    <= 1'b0;
      wrap    <= 1'b0;
      case (state)
        S_SYNC: begin
          if (legal) begin
            prev  <= sidx;
            index <= sidx;
            state <= S_LOCK;
            valid <= 1'b1;
          end
        end
        S_LOCK: begin
          if (adj) begin
            prev  <= sidx;
            index <= sidx;
            if (diff == 3'd1) begin
              dir_down   <= 1'b0;
              step       <= 1'b1;
              step_count <= step_count + 1'b1;
              wrap       <= (prev == 3'd7);
            end else if (diff == 3'd7) begin
              dir_down   <= 1'b1;
              step       <= 1'b1;
              step_count <= step_count + 1'b1;
              wrap       <= (prev == 3'd0);
            end
          end else begin
            state    <= S_FAULT;
            valid    <= 1'b0;
            good_cnt <= '0;
            anchor   <= 1'b0;
            if (error_count != '1)
              error_count <= error_count + 1'b1;
          end
        end
        S_FAULT: begin
          // First legal code after the fault re-anchors the tracker
          if (legal && (!anchor || adj)) begin
            anchor <= 1'b1;
            prev   <= sidx;
            index  <= sidx;
            if (int'(good_cnt) + 1 >= RESYNC_N) begin
              state    <= S_LOCK;
              valid    <= 1'b1;
              good_cnt <= '0;
            end else begin
              good_cnt <= good_cnt + 1'b1;
            end
          end else begin
            good_cnt <= '0;
          end
        end
        default: state <= S_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_johnson_monitor.sv
// Scoreboard bench for johnson_monitor: a behavioural model queues the
// expected outputs per sample; they are checked after each clock edge.
module tb_johnson_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] signal;
  logic [2:0] index;
  logic       valid, dir_down, step, wrap, illegal;
  logic [7:0] step_count;
  logic [3:0] error_count;

  johnson_monitor #(.CNT_W(8), .ERR_W(4), .RESYNC_N(2)) dut (
    .clk(clk), .reset(reset), .signal(signal),
    .index(index), .valid(valid), .dir_down(dir_down),
    .step(step), .wrap(wrap), .illegal(illegal),
    .step_count(step_count), .error_count(error_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] index;
    logic       valid, dir_down, step, wrap, illegal;
    logic [7:0] sc;
    logic [3:0] ec;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_run = 0;
  int   n_fail = 0;

  logic [3:0] codes [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                            4'b1111, 4'b1110, 4'b1100, 4'b1000};

  int m_state = 0;
  int m_prev = 0;
  int m_good = 0;
  bit m_anchor = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int c2i(input logic [3:0] c);
    for (int i = 0; i < 8; i++)
      if (codes[i] == c) return i;
    return -1;
  endfunction

  task automatic model(input logic rst, input logic [3:0] s);
    int i, d;
    bit near;
    if (rst) begin
      e = '{index: 0, valid: 0, dir_down: 0, step: 0, wrap: 0,
            illegal: 0, sc: 0, ec: 0};
      m_state = 0; m_prev = 0; m_good = 0; m_anchor = 0;
      return;
    end
    i = c2i(s);
    e.illegal = (i < 0);
    e.step = 0;
    e.wrap = 0;
    d = (i - m_prev + 8) % 8;
    near = (i >= 0) && (d == 0 || d == 1 || d == 7);
    if (m_state == 0) begin
      if (i >= 0) begin
        m_prev = i; e.index = i[2:0]; m_state = 1; e.valid = 1;
      end
    end else if (m_state == 1) begin
      if (near) begin
        if (d == 1) begin
          e.dir_down = 0; e.step = 1; e.sc = e.sc + 1;
          e.wrap = (m_prev == 7);
        end else if (d == 7) begin
          e.dir_down = 1; e.step = 1; e.sc = e.sc + 1;
          e.wrap = (m_prev == 0);
        end
        m_prev = i; e.index = i[2:0];
      end else begin
        m_state = 2; e.valid = 0; m_good = 0; m_anchor = 0;
        if (e.ec < 15) e.ec = e.ec + 1;
      end
    end else begin
      if (i >= 0 && (!m_anchor || near)) begin
        m_anchor = 1; m_prev = i; e.index = i[2:0];
        m_good++;
        if (m_good >= 2) begin
          m_state = 1; e.valid = 1; m_good = 0;
        end
      end else begin
        m_good = 0;
      end
    end
  endtask

  task automatic drive(input logic rst, input logic [3:0] s);
    exp_t x;
    @(negedge clk);
    reset = rst;
    signal = s;
    model(rst, s);
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk("queue", 0, 1);
      return;
    end
    x = q.pop_front();
    chk("index", index, x.index);
    chk("valid", valid, x.valid);
    chk("dir_down", dir_down, x.dir_down);
    chk("step", step, x.step);
    chk("wrap", wrap, x.wrap);
    chk("illegal", illegal, x.illegal);
    chk("step_count", step_count, x.sc);
    chk("error_count", error_count, x.ec);
  endtask

  initial begin
    int cur;
    reset = 1'b1;
    signal = 4'b0101;
    drive(1, 4'b0101);
    drive(1, 4'b0101);
    // descending lap including the 0->7 wrap
    drive(0, 4'b0000);
    for (int k = 7; k >= 0; k--) drive(0, codes[k]);
    chk("lap_down_cnt", step_count, 8);
    // ascending lap including the 7->0 wrap
    for (int k = 1; k <= 8; k++) drive(0, codes[k % 8]);
    drive(0, 4'b0001);
    repeat (3) drive(0, 4'b0011);
    chk("hold_index", index, 2);
    // illegal code, then resync
    drive(0, 4'b0101);
    drive(0, 4'b0011);
    drive(0, 4'b0111);
    chk("resync_valid", valid, 1);
    drive(0, 4'b1111);
    drive(0, 4'b0111);
    drive(0, 4'b0011);
    drive(0, 4'b0001);
    // skip 1 -> 4
    drive(0, 4'b1111);
    chk("skip_index", index, 1);
    drive(0, 4'b1111);
    drive(0, 4'b1110);
    // random walk with occasional garbage
    cur = 5;
    repeat (60) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) drive(0, 4'($urandom_range(0, 15)));
      else begin
        if (r < 5) cur = (cur + 1) % 8;
        else if (r < 9) cur = (cur + 7) % 8;
        drive(0, codes[cur]);
      end
    end
    // saturate error_count
    repeat (17) begin
      drive(0, 4'b0101);
      drive(0, 4'b0000);
      drive(0, 4'b0000);
    end
    drive(0, 4'b0101);
    chk("err_sat", error_count, 15);
    drive(1, 4'b0000);
    drive(0, 4'b0101);
    drive(0, 4'b0011);
    drive(0, 4'b0111);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
